// File: rtl/minterm_pkg.sv
// Shared types and helpers for the minterm sweeper.
//   state_t  : sweeper FSM states
//   ORDER_*  : sweep order selectors
//   to_gray  : binary-reflected Gray code of a step number
package minterm_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  localparam int unsigned ORDER_BIN  = 0;
  localparam int unsigned ORDER_GRAY = 1;

  // Widest step handled by to_gray; callers cast down to their own width.
  localparam int unsigned MAX_VARS = 16;

  function automatic logic [MAX_VARS-1:0] to_gray(input logic [MAX_VARS-1:0] step);
    return step ^ (step >> 1);
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// Step counter for the minterm sweep.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart at step 0 (wins over advance)
//   advance     : move to the next step
//   next_index  : minterm index the counter will present after this edge
//                 (index 0 on clear, order(step+1) otherwise)
//   last        : current step is the final one (TT_W-1)
module sweep_counter
  import minterm_pkg::*;
#(
  parameter int unsigned N_VARS = 4,
  parameter int unsigned ORDER  = ORDER_BIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [N_VARS-1:0] next_index,
  output logic              last
);

  localparam int unsigned TT_W = 1 << N_VARS;

  logic [N_VARS-1:0] step;
  logic [N_VARS-1:0] step_inc;

  // Map a step number onto the minterm index for the configured order.
  function automatic logic [N_VARS-1:0] order_of(input logic [N_VARS-1:0] v);
    if (ORDER == ORDER_GRAY) return N_VARS'(to_gray(MAX_VARS'(v)));
    else                     return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) step <= '0;
    else if (advance) step <= step_inc;
  end

  assign step_inc   = step + N_VARS'(1);
  assign next_index = clear ? '0 : order_of(step_inc);
  assign last       = (step == N_VARS'(TT_W - 1));

endmodule

// File: rtl/minterm_sweeper.sv
// Sweeps all 2^N_VARS minterms of a latched truth table and streams (m, s)
// pairs over a valid/ready handshake while counting accepted ones.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a sweep (honoured only when idle)
//   tt                : truth table, tt[k] = f(k); latched on accepted start
//   m_ready           : consumer accepts the current entry
//   busy              : sweeper not idle
//   m_valid, m, s     : current entry (minterm index, function value)
//   ones_cnt          : ones accepted so far; final with done
//   done              : one-cycle pulse after the last entry is accepted
// Optional (macro CHECK_EN):
//   exp_tt            : expected truth table, latched with tt
//   mism              : s differs from the expected value for m
//   mism_cnt          : accepted entries with mism set
module minterm_sweeper
  import minterm_pkg::*;
#(
  parameter int unsigned N_VARS = 4,
  parameter int unsigned ORDER  = ORDER_BIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [(1<<N_VARS)-1:0]   tt,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     m_valid,
  output logic [N_VARS-1:0]        m,
  output logic                     s,
  output logic [N_VARS:0]          ones_cnt,
  output logic                     done
`ifdef CHECK_EN
  ,
  input  logic [(1<<N_VARS)-1:0]   exp_tt,
  output logic                     mism,
  output logic [N_VARS:0]          mism_cnt
`endif
);

  localparam int unsigned TT_W = 1 << N_VARS;
  localparam int unsigned CW   = N_VARS + 1;

  state_t            state;
  logic [TT_W-1:0]   tt_q;
  logic [N_VARS-1:0] next_index;
  logic              last;
  logic              accept;
  logic              clear;
  logic              advance;
`ifdef CHECK_EN
  logic [TT_W-1:0]   exp_q;
`endif

  assign accept  = (state == ST_SWEEP) && m_valid && m_ready;
  assign clear   = (state == ST_IDLE) && start;
  assign advance = accept && !last;

  sweep_counter #(
    .N_VARS (N_VARS),
    .ORDER  (ORDER)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .advance    (advance),
    .next_index (next_index),
    .last       (last)
  );

  // FSM, handshake and counters; the first entry reads tt directly since it
  // is being latched on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tt_q     <= '0;
      busy     <= 1'b0;
      m_valid  <= 1'b0;
      m        <= '0;
      s        <= 1'b0;
      ones_cnt <= '0;
      done     <= 1'b0;
`ifdef CHECK_EN
      exp_q    <= '0;
      mism     <= 1'b0;
      mism_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_SWEEP;
            tt_q     <= tt;
            busy     <= 1'b1;
            m_valid  <= 1'b1;
            m        <= next_index;
            s        <= tt[next_index];
            ones_cnt <= '0;
`ifdef CHECK_EN
            exp_q    <= exp_tt;
            mism     <= tt[next_index] ^ exp_tt[next_index];
            mism_cnt <= '0;
`endif
          end
        end
        ST_SWEEP: begin
          if (accept) begin
            ones_cnt <= ones_cnt + CW'(s);
`ifdef CHECK_EN
            mism_cnt <= mism_cnt + CW'(mism);
`endif
            if (last) begin
              state   <= ST_DONE;
              m_valid <= 1'b0;
              done    <= 1'b1;
            end else begin
              m <= next_index;
              s <= tt_q[next_index];
`ifdef CHECK_EN
              mism <= tt_q[next_index] ^ exp_q[next_index];
`endif
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          m_valid <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
